// File: rtl/light_pkg.sv
// Shared constants and state encoding for the light/sensor channel scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package light_pkg;

  localparam int NUM_CH          = 8;
  localparam int CH_W            = 3;
  localparam int DEFAULT_DWELL_W = 16;

  // Scanner FSM encoding, kept as plain constants so older blocks can reuse it.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DWELL  = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;

endpackage

// File: rtl/next_chan_pick.sv
// Rotated priority encoder: first set mask bit strictly above sel, wrapping to bit 0.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake on this path.
module next_chan_pick
  import light_pkg::*;
(
  input  logic [NUM_CH-1:0] chan_mask,
  input  logic [CH_W-1:0]   sel,
  output logic [CH_W-1:0]   next,
  output logic              wrap,
  output logic              none
);

  logic [CH_W-1:0] idx;

  // Scan from farthest to nearest so the nearest set bit above sel wins; with
  // sel = 7 this degenerates into a plain lowest-set-bit pick.
  always_comb begin
    next = sel;
    idx  = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = sel + CH_W'(i);
      if (chan_mask[idx]) next = idx;
    end
    none = (chan_mask == '0);
    wrap = !none && (next <= sel);
  end

endmodule

// File: rtl/light_scan_sequencer.sv
// Walks enabled light channels in order, dwelling on each before a req/ack sensor sample.
// Latency: sel valid the cycle after enable; sample_req rises max(dwell,1) cycles after each channel load.
// Backpressure: sample_req and sel hold until sample_ack; a late ack simply stretches the channel period.
module light_scan_sequencer
  import light_pkg::*;
#(
  parameter int DWELL_W = DEFAULT_DWELL_W,
  parameter int NUM_CH  = light_pkg::NUM_CH
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NUM_CH-1:0]  chan_mask,
  output logic [CH_W-1:0]    sel,
  output logic               sel_valid,
  output logic               sample_req,
  input  logic               sample_ack,
  output logic               frame_done
);

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_load;
  logic [CH_W-1:0]    pick_sel;
  logic [CH_W-1:0]    pick_next;
  logic               pick_wrap;
  logic               pick_none;

  // A dwell of 0 behaves like 1: the counter counts down to zero, then requests.
  always_comb begin
    dwell_load = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    // From IDLE, searching above channel 7 yields the lowest enabled channel.
    pick_sel   = (state == ST_IDLE) ? CH_W'(NUM_CH - 1) : sel;
  end

  next_chan_pick u_pick (
    .chan_mask (chan_mask),
    .sel       (pick_sel),
    .next      (pick_next),
    .wrap      (pick_wrap),
    .none      (pick_none)
  );

  // Scanner FSM; every output is a register so the decoder sees no input glitches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      sel        <= '0;
      sel_valid  <= 1'b0;
      sample_req <= 1'b0;
      frame_done <= 1'b0;
      cnt        <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable && !pick_none) begin
            sel       <= pick_next;
            sel_valid <= 1'b1;
            cnt       <= dwell_load;
            state     <= ST_DWELL;
          end else begin
            sel_valid <= 1'b0;
          end
        end
        ST_DWELL: begin
          if (!enable) begin
            sel_valid <= 1'b0;
            state     <= ST_IDLE;
          end else if (cnt == '0) begin
            sample_req <= 1'b1;
            state      <= ST_SAMPLE;
          end else begin
            cnt <= cnt - DWELL_W'(1);
          end
        end
        ST_SAMPLE: begin
          // enable is deliberately ignored until the outstanding sample is acked.
          if (sample_ack) begin
            sample_req <= 1'b0;
            frame_done <= pick_wrap;
            if (!enable || pick_none) begin
              sel_valid <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              sel   <= pick_next;
              cnt   <= dwell_load;
              state <= ST_DWELL;
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          sel_valid  <= 1'b0;
          sample_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
